memoria_mascara: RTL

Register-based coefficient store for the filter mask, holding up to 2^BITS_DIRECCION coefficients. It sits between the mask loader, which writes coefficients, and the mask reader FSM. It is the responder side of the read handshake: the reader raises `leer` with `direccion_mem` and waits for `lectura_completada`. A fixed, parameterised read latency models the external mask memory, and addresses outside the current mask size are flagged.

---
 rtl/memoria_mascara_if.sv | 29 ++
 rtl/memoria_mascara.sv | 103 ++++++++++
 2 files changed

// File: rtl/memoria_mascara_if.sv
// Write and read-handshake bundle between the mask loader/reader (master)
// and the mask coefficient store (slave).
interface memoria_mascara_if #(
   parameter int unsigned BITS_DATOS     = 8,
   parameter int unsigned BITS_DIRECCION = 6
);
   logic [2:0]                tamano_mascara;
   logic                      escribir;
   logic [BITS_DIRECCION-1:0] direccion_escritura;
   logic [BITS_DATOS-1:0]     dato_escritura;
   logic                      leer;
   logic [BITS_DIRECCION-1:0] direccion_mem;
   logic [BITS_DATOS-1:0]     dato_leido;
   logic                      lectura_completada;
   logic                      error_direccion;
   logic                      ocupado;

   modport master (
      output tamano_mascara, escribir, direccion_escritura, dato_escritura,
             leer, direccion_mem,
      input  dato_leido, lectura_completada, error_direccion, ocupado
   );

   modport slave (
      input  tamano_mascara, escribir, direccion_escritura, dato_escritura,
             leer, direccion_mem,
      output dato_leido, lectura_completada, error_direccion, ocupado
   );
endinterface

// File: rtl/memoria_mascara.sv
// Register-based filter-mask coefficient store with a fixed read latency
// and out-of-range address flagging against the current mask size.
module memoria_mascara #(
   parameter int unsigned BITS_DATOS     = 8,
   parameter int unsigned BITS_DIRECCION = 6,
   parameter int unsigned LATENCIA       = 2
) (
   input  logic             clk,
   input  logic             reset,
   memoria_mascara_if.slave bus
);
   localparam int unsigned PROFUNDIDAD = 1 << BITS_DIRECCION;
   localparam int unsigned BITS_LIMITE = 6;
   localparam int unsigned BITS_CMP    = (BITS_DIRECCION > BITS_LIMITE) ? BITS_DIRECCION : BITS_LIMITE;
   localparam int unsigned BITS_CONT   = 4;

   typedef enum logic [1:0] {
      E_REPOSO  = 2'd0,
      E_ESPERA  = 2'd1,
      E_ENTREGA = 2'd2
   } estado_t;

   estado_t                   r_estado;
   logic [BITS_DATOS-1:0]     r_mem [PROFUNDIDAD];
   logic [BITS_DIRECCION-1:0] r_direccion;
   logic [BITS_LIMITE-1:0]    r_limite;
   logic [BITS_CONT-1:0]      r_contador;
   logic [BITS_DATOS-1:0]     r_dato_leido;
   logic                      r_completada;
   logic                      r_error;
   logic                      r_ocupado;

   logic [BITS_LIMITE-1:0]    w_producto;
   logic                      w_en_rango;

   assign w_producto = BITS_LIMITE'(bus.tamano_mascara) * BITS_LIMITE'(bus.tamano_mascara);
   assign w_en_rango = BITS_CMP'(r_direccion) < BITS_CMP'(r_limite);

   // Array, FSM and registered outputs share one process so capture sees pre-edge array contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(PROFUNDIDAD); i++) r_mem[i] <= '0;
         r_estado     <= E_REPOSO;
         r_direccion  <= '0;
         r_limite     <= '0;
         r_contador   <= '0;
         r_dato_leido <= '0;
         r_completada <= 1'b0;
         r_error      <= 1'b0;
         r_ocupado    <= 1'b0;
      end else begin
         if (bus.escribir) r_mem[bus.direccion_escritura] <= bus.dato_escritura;
         r_completada <= 1'b0;
         r_error      <= 1'b0;
         case (r_estado)
            E_REPOSO: begin
               if (bus.leer) begin
                  r_direccion <= bus.direccion_mem;
                  r_limite    <= w_producto;
                  r_contador  <= BITS_CONT'(LATENCIA - 1);
                  r_ocupado   <= 1'b1;
                  r_estado    <= E_ESPERA;
               end
            end
            E_ESPERA: begin
               if (r_contador == '0) begin
                  r_estado     <= E_ENTREGA;
                  r_completada <= 1'b1;
                  if (w_en_rango) begin
                     r_dato_leido <= r_mem[r_direccion];
                  end else begin
                     r_dato_leido <= '0;
                     r_error      <= 1'b1;
                  end
               end else begin
                  r_contador <= r_contador - BITS_CONT'(1);
               end
            end
            E_ENTREGA: begin
               // A request on the edge leaving delivery is taken back-to-back
               if (bus.leer) begin
                  r_direccion <= bus.direccion_mem;
                  r_limite    <= w_producto;
                  r_contador  <= BITS_CONT'(LATENCIA - 1);
                  r_estado    <= E_ESPERA;
               end else begin
                  r_ocupado <= 1'b0;
                  r_estado  <= E_REPOSO;
               end
            end
            default: begin
               r_ocupado <= 1'b0;
               r_estado  <= E_REPOSO;
            end
         endcase
      end
   end

   assign bus.dato_leido         = r_dato_leido;
   assign bus.lectura_completada = r_completada;
   assign bus.error_direccion    = r_error;
   assign bus.ocupado            = r_ocupado;
endmodule
